// File: rtl/division_check_mul_if.sv
// Operand/result bundle for the shift-and-add reconstruction multiplier.
// The master drives start and Q/D/R; the slave returns N with its status flags.
interface division_check_mul_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   D;
  logic [WIDTH-1:0]   R;
  logic [2*WIDTH-1:0] N;
  logic               busy;
  logic               done;
  logic               ovf;
  logic               rem_err;

  modport master (
    output start,
    output Q,
    output D,
    output R,
    input  N,
    input  busy,
    input  done,
    input  ovf,
    input  rem_err
  );

  modport slave (
    input  start,
    input  Q,
    input  D,
    input  R,
    output N,
    output busy,
    output done,
    output ovf,
    output rem_err
  );
endinterface

// File: rtl/division_check_mul.sv
// Sequential N = Q*D + R, one multiplier bit per clock, with a start/busy/done handshake.
// It also flags remainders that are not strictly below the divisor.
module division_check_mul #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  division_check_mul_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rem_pend_q, rem_pend_d;
  logic [2*WIDTH-1:0] n_q, n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               rem_err_q, rem_err_d;
  logic [2*WIDTH-1:0] acc_sum;

  // Accumulator plus the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_sum = acc_q;
    if (mplier_q[0]) begin
      acc_sum = acc_q + mcand_q;
    end else begin
      acc_sum = acc_q;
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    rem_pend_d = rem_pend_q;
    n_d        = n_q;
    ovf_d      = ovf_q;
    rem_err_d  = rem_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d      = {{WIDTH{1'b0}}, bus.R};
          mcand_d    = {{WIDTH{1'b0}}, bus.D};
          mplier_d   = bus.Q;
          cnt_d      = {CW{1'b0}};
          rem_pend_d = (bus.R >= bus.D);
          state_d    = S_RUN;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The WIDTH-th RUN edge publishes the result together with its flags.
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          n_d       = acc_sum;
          ovf_d     = |acc_sum[2*WIDTH-1:WIDTH];
          rem_err_d = rem_pend_q;
        end else begin
          state_d   = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= {(2*WIDTH){1'b0}};
      mcand_q    <= {(2*WIDTH){1'b0}};
      mplier_q   <= {WIDTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
      rem_pend_q <= 1'b0;
      n_q        <= {(2*WIDTH){1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      rem_pend_q <= rem_pend_d;
      n_q        <= n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      rem_err_q  <= rem_err_d;
    end
  end

  assign bus.N       = n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.rem_err = rem_err_q;

endmodule

// File: tb/tb_division_check_mul.sv
// Directed bench for division_check_mul: reset, latency, extremes, ignored start,
// mid-operation reset and a back-to-back round trip against a divider model.
module tb_division_check_mul;

  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  division_check_mul_if #(.WIDTH(WIDTH)) bus ();

  division_check_mul #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation from idle; optionally re-asserts start mid-run with a new Q.
  task automatic run_op(input string tag, input logic [15:0] q, input logic [15:0] d,
                        input logic [15:0] r, input logic [31:0] exp_n,
                        input logic exp_ovf, input logic exp_err, input bit poke);
    int busy_cnt;
    int done_cnt;
    int done_k;
    bus.Q = q;
    bus.D = d;
    bus.R = r;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.Q = 16'h1234;
    bus.D = 16'h0042;
    bus.R = 16'h7777;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    done_cnt = 0;
    done_k   = -1;
    for (int k = 1; k <= 22; k++) begin
      if (poke && k == 5) begin
        bus.start = 1'b1;
        bus.Q = 16'd1;
      end
      if (poke && k == 8) begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
    end
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " done_edge"}, 64'(done_k), 64'd16);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd17);
    check({tag, " N"}, 64'(bus.N), 64'(exp_n));
    check({tag, " ovf"}, 64'(bus.ovf), 64'(exp_ovf));
    check({tag, " rem_err"}, 64'(bus.rem_err), 64'(exp_err));
  endtask

  initial begin
    logic [15:0] rt_n [0:999];
    logic [15:0] rt_d [0:999];
    int done_seen;
    int last_done;
    int cyc;
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.Q = 16'd0;
    bus.D = 16'd0;
    bus.R = 16'd0;

    // Reset then idle with operands present but no start.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.Q = 16'd5;
    bus.D = 16'd7;
    bus.R = 16'd3;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("idle_outputs", {27'd0, bus.busy, bus.done, bus.ovf, bus.rem_err, bus.N},
            64'd0);
    end

    // 25*4+3 = 103
    run_op("basic", 16'd25, 16'd4, 16'd3, 32'd103, 1'b0, 1'b0, 1'b0);
    // 0xFFFF*0xFFFF+0xFFFF = 0xFFFF0000
    run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000, 1'b1, 1'b1, 1'b0);
    run_op("zero", 16'd0, 16'd0, 16'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    // 100*3+2 = 302, mid-run start must be ignored
    run_op("ignored_start", 16'd100, 16'd3, 16'd2, 32'd302, 1'b0, 1'b0, 1'b1);

    // Reset at the 8th RUN edge discards the operation.
    bus.Q = 16'd9;
    bus.D = 16'd9;
    bus.R = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_N", 64'(bus.N), 64'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.done === 1'b1) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);
    run_op("after_rst", 16'd9, 16'd9, 16'd0, 32'd81, 1'b0, 1'b0, 1'b0);

    // Round trip: divider model gives Q=N'/D', R=N'%D'; start held high throughout.
    for (int v = 0; v < 1000; v++) begin
      rt_n[v] = 16'($urandom_range(65535, 0));
      rt_d[v] = 16'($urandom_range(65535, 1));
    end
    cyc = 0;
    last_done = 0;
    bus.Q = rt_n[0] / rt_d[0];
    bus.D = rt_d[0];
    bus.R = rt_n[0] % rt_d[0];
    bus.start = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      done_seen = 0;
      for (int k = 0; k < 40 && done_seen == 0; k++) begin
        tick();
        cyc++;
        if (bus.done === 1'b1) done_seen = 1;
      end
      check("rt_done_timeout", 64'(done_seen), 64'd1);
      if (done_seen == 0) break;
      check("rt_result", {29'd0, bus.ovf, bus.rem_err, 1'b0, bus.N},
            {33'd0, 15'd0, rt_n[v]});
      if (v > 0) check("rt_period", 64'(cyc - last_done), 64'd18);
      last_done = cyc;
      if (v < 999) begin
        bus.Q = rt_n[v+1] / rt_d[v+1];
        bus.D = rt_d[v+1];
        bus.R = rt_n[v+1] % rt_d[v+1];
      end
    end
    bus.start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
